// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial 8x8 multiplier.
// The master side is the operand producer and result consumer. The slave side is the sequencer.
interface mul8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiplier built by stepping one shared 4x4 multiplier through
// the four nibble partial products, with valid/ready on both sides.

module multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = a * b;
endmodule

module mul8_seq_ctrl #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mul8_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [7:0]  ra, rb;
  logic [15:0] acc;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic [15:0] pp_shifted;
  logic        accept;
  logic        zero_op;

  multiplier u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  assign accept  = (state == IDLE) && bus.in_valid;
  assign zero_op = (bus.a == 8'd0) || (bus.b == 8'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = (ZERO_SKIP && zero_op) ? DONE : PP0;
      PP0:  state_next = PP1;
      PP1:  state_next = PP2;
      PP2:  state_next = PP3;
      PP3:  state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiplier operands come only from the latched registers, so a/b may
  // change freely once accepted; partial products are zero-extended before shifting.
  always_comb begin
    mul_a      = 4'h0;
    mul_b      = 4'h0;
    pp_shifted = 16'h0000;
    case (state)
      PP0: begin
        mul_a      = ra[3:0];
        mul_b      = rb[3:0];
        pp_shifted = {8'h00, mul_p};
      end
      PP1: begin
        mul_a      = ra[7:4];
        mul_b      = rb[3:0];
        pp_shifted = {4'h0, mul_p, 4'h0};
      end
      PP2: begin
        mul_a      = ra[3:0];
        mul_b      = rb[7:4];
        pp_shifted = {4'h0, mul_p, 4'h0};
      end
      PP3: begin
        mul_a      = ra[7:4];
        mul_b      = rb[7:4];
        pp_shifted = {mul_p, 8'h00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra  <= 8'h00;
      rb  <= 8'h00;
      acc <= 16'h0000;
    end else if (accept) begin
      ra  <= bus.a;
      rb  <= bus.b;
      acc <= 16'h0000;
    end else if (state inside {PP0, PP1, PP2, PP3}) begin
      acc <= acc + pp_shifted;
    end
  end

  // The product register doubles as the output; it only changes in the
  // compute states, so it is stable for the whole of DONE.
  assign bus.p         = acc;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl: directed scenarios plus a random
// stream, with expected products queued at accept and compared on output.
module tb_mul8_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mul8_seq_ctrl_if bus ();
  mul8_seq_ctrl_if bus0 ();

  mul8_seq_ctrl #(.ZERO_SKIP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mul8_seq_ctrl #(.ZERO_SKIP(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] sb[$];

  // Assumes the caller is at a negedge; returns at the negedge after accept.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
    end else begin
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      @(posedge clk);
      sb.push_back(16'(a) * 16'(b));
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Counts rising edges since the accept edge (which already occurred).
  task automatic wait_out(output int edges);
    edges = 1;
    while (!bus.out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic consume(input string name);
    logic [15:0] exp;
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid: out_valid=%b required 1", name, bus.out_valid);
    end else if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_extra: p=%h produced with nothing expected", name, bus.p);
    end else begin
      exp = sb.pop_front();
      if (bus.p !== exp) begin
        miscompares++;
        $display("FAIL %s_p: p=%h required %h", name, bus.p, exp);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.p} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy/vld/busy/p=%b%b%b/%h required 100/0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.p);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: rdy/busy/vld=%b%b%b required 100",
               bus.in_ready, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    int edges;
    send(8'h0F, 8'h0F);
    wait_out(edges);
    vectors++;
    if (edges !== 5) begin
      miscompares++;
      $display("FAIL basic_latency: edges=%0d required 5", edges);
    end
    consume("basic");
    vectors++;
    if ({bus.in_ready, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_idle: rdy/busy=%b%b required 10", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_stall();
    int edges;
    int bad = 0;
    send(8'hFF, 8'hFF);
    wait_out(edges);
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.p !== 16'hFE01) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stall_hold: %0d unstable cycles, last p=%h vld=%b required FE01/1",
               bad, bus.p, bus.out_valid);
    end
    consume("stall");
    vectors++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL stall_idle: rdy/busy/vld=%b%b%b required 100",
               bus.in_ready, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_zero_skip();
    int edges;
    send(8'h00, 8'h5A);
    wait_out(edges);
    vectors++;
    if (edges !== 1) begin
      miscompares++;
      $display("FAIL zskip_latency: edges=%0d required 1", edges);
    end
    consume("zskip");

    // Same operands on the instance that always runs all four steps.
    bus0.in_valid = 1'b1;
    bus0.a        = 8'h00;
    bus0.b        = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    edges = 1;
    while (!bus0.out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    vectors++;
    if (edges !== 5) begin
      miscompares++;
      $display("FAIL noskip_latency: edges=%0d required 5", edges);
    end
    vectors++;
    if (bus0.p !== 16'h0000) begin
      miscompares++;
      $display("FAIL noskip_p: p=%h required 0000", bus0.p);
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int edges;
    int bad = 0;
    send(8'h12, 8'h34);
    bus.in_valid = 1'b1;
    bus.a        = 8'hAA;
    bus.b        = 8'hBB;
    for (int i = 0; i < 40 && !bus.out_valid; i++) begin
      if (bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL busy_ready: in_ready high %0d times while busy, required 0", bad);
    end
    consume("busy_first");
    send(8'hAA, 8'hBB);
    wait_out(edges);
    consume("busy_second");
  endtask

  task automatic test_reset_mid();
    int edges;
    int seen = 0;
    send(8'hC3, 8'h7E);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.p} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL midrst_outputs: rdy/vld/busy/p=%b%b%b/%h required 100/0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.p);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL midrst_novalid: out_valid seen %0d cycles, required 0", seen);
    end
    send(8'h03, 8'h05);
    wait_out(edges);
    consume("midrst_after");
  endtask

  task automatic test_random();
    localparam int N = 500;
    int got = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [7:0] ra, rb;
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) ra = 8'h00;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(ra, rb);
        end
      end
      begin
        int cyc = 0;
        while (got < N && cyc < 20000) begin
          logic r;
          @(negedge clk);
          cyc++;
          r = 1'($urandom_range(0, 1));
          if (bus.out_valid && r) begin
            vectors++;
            if (sb.size() == 0) begin
              miscompares++;
              $display("FAIL rand_extra: p=%h produced with nothing expected", bus.p);
            end else begin
              logic [15:0] exp;
              exp = sb.pop_front();
              if (bus.p !== exp) begin
                miscompares++;
                $display("FAIL rand_p[%0d]: p=%h required %h", got, bus.p, exp);
              end
            end
            got++;
          end
          bus.out_ready = r;
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b0;
    vectors++;
    if (got != N || sb.size() != 0) begin
      miscompares++;
      $display("FAIL rand_count: received %0d with %0d pending, required %0d and 0",
               got, sb.size(), N);
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.a          = 8'h00;
    bus.b          = 8'h00;
    bus.out_ready  = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.a         = 8'h00;
    bus0.b         = 8'h00;
    bus0.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_skip();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
